// File: rtl/controlador_contador_if.sv
// Bundle of control, status and counter-side signals for controlador_contador.
// master: the job requester / counter environment; slave: the controller.
interface controlador_contador_if #(
  parameter int W = 4,
  parameter int R = 4
);
  logic         start;
  logic         abort;
  logic         pause;
  logic [W-1:0] limit;
  logic [R-1:0] reps;
  logic [W-1:0] count_in;
  logic         cnt_clr;
  logic         cnt_en;
  logic         busy;
  logic         done;
  logic [R-1:0] rep_idx;
  logic         err;

  modport master (
    output start, abort, pause, limit, reps, count_in,
    input  cnt_clr, cnt_en, busy, done, rep_idx, err
  );

  modport slave (
    input  start, abort, pause, limit, reps, count_in,
    output cnt_clr, cnt_en, busy, done, rep_idx, err
  );
endinterface

// File: rtl/controlador_contador.sv
// Controller for an external W-bit up-counter: runs `reps` passes, each one
// clearing the counter and enabling it until it reaches the latched limit.
// A W+1-bit watchdog aborts a pass with err after 2^W enabled cycles.
module controlador_contador #(
  parameter int W = 4,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  controlador_contador_if.slave ctl
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [W:0]   WD_ONE  = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   WD_MAX  = {1'b1, {W{1'b0}}};
  localparam logic [R-1:0] REP_ONE = {{(R-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [W-1:0] lim_q, lim_d;
  logic [R-1:0] reps_q, reps_d;
  logic [R-1:0] rep_idx_q, rep_idx_d;
  logic         err_q, err_d;
  logic [W:0]   wd_q, wd_d;
  logic         match;
  logic         en;

  // Counter-facing strobes and status outputs, all decoded from current state.
  always_comb begin
    match       = (ctl.count_in == lim_q);
    en          = (state_q == S_RUN) & ~reset & ~ctl.abort & ~ctl.pause & ~match;
    ctl.cnt_en  = en;
    ctl.cnt_clr = (state_q == S_CLEAR) & ~reset;
    ctl.busy    = (state_q == S_CLEAR) | (state_q == S_RUN);
    ctl.done    = (state_q == S_DONE);
    ctl.rep_idx = rep_idx_q;
    ctl.err     = err_q;
  end

  // Next-state logic; in RUN the order is abort > match > pause > watchdog.
  always_comb begin
    state_d   = state_q;
    lim_d     = lim_q;
    reps_d    = reps_q;
    rep_idx_d = rep_idx_q;
    err_d     = err_q;
    wd_d      = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctl.start && !ctl.abort) begin
          lim_d     = ctl.limit;
          reps_d    = ctl.reps;
          rep_idx_d = '0;
          err_d     = 1'b0;
          wd_d      = '0;
          if (ctl.reps == '0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
        end else begin
          wd_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
        end else if (match) begin
          rep_idx_d = rep_idx_q + REP_ONE;
          state_d   = (rep_idx_d == reps_q) ? S_DONE : S_CLEAR;
        end else if (!ctl.pause) begin
          wd_d = wd_q + WD_ONE;
          if (wd_d == WD_MAX) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and job registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lim_q     <= '0;
      reps_q    <= '0;
      rep_idx_q <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      reps_q    <= reps_d;
      rep_idx_q <= rep_idx_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

endmodule
